mul_div_ctrl: RTL and testbench

MUL_DIV_CTRL -- requirements
Module: mul_div_ctrl

---
 rtl/mul_div_pkg.sv | 33 +++
 rtl/mul_div_ctrl_div_iter.sv | 106 ++++++++++
 rtl/mul_div_ctrl.sv | 181 ++++++++++++++++++
 tb/tb_mul_div_ctrl.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mul_div_pkg.sv
// mul_div_pkg
//   Shared definitions for the HI/LO multiply/divide controller:
//   operation encoding, controller state encoding and the divider
//   iteration-counter width helper.
package mul_div_pkg;

  typedef enum logic [2:0] {
    OP_MULT  = 3'd0,
    OP_MULTU = 3'd1,
    OP_DIV   = 3'd2,
    OP_DIVU  = 3'd3,
    OP_MTHI  = 3'd4,
    OP_MTLO  = 3'd5,
    OP_MFHI  = 3'd6,
    OP_MFLO  = 3'd7
  } op_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2
  } state_t;

  localparam int DATA_W_DEF = 32;

  // The iteration counter must hold the value DATA_W itself.
  function automatic int div_iter_w(input int data_w);
    return $clog2(data_w + 1);
  endfunction

  localparam int DIV_ITER_W = div_iter_w(DATA_W_DEF);

endpackage

// File: rtl/mul_div_ctrl_div_iter.sv
// div_iter
//   Radix-2 restoring divider. A start pulse loads the operand magnitudes;
//   DATA_W iterations follow, then one sign-fix cycle in which done=1 and
//   quotient/remainder carry the final, sign-corrected values. kill
//   abandons the operation at the next edge.
//
//   Ports
//     clk, resetn          clock, asynchronous active-low reset
//     start                load operands and begin (one cycle)
//     signed_mode          1: two's-complement divide, 0: unsigned
//     kill                 abandon the operation in progress
//     dividend, divisor    operands, sampled on start
//     done                 high for the single sign-fix cycle
//     quotient, remainder  results, valid while done=1
module div_iter
  import mul_div_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              start,
  input  logic              signed_mode,
  input  logic              kill,
  input  logic [DATA_W-1:0] dividend,
  input  logic [DATA_W-1:0] divisor,
  output logic              done,
  output logic [DATA_W-1:0] quotient,
  output logic [DATA_W-1:0] remainder
);

  localparam int ITER_W = div_iter_w(DATA_W);
  localparam logic [ITER_W-1:0] ITER_LOAD = ITER_W'(DATA_W);

  logic              active;
  logic [ITER_W-1:0] count;
  logic [DATA_W-1:0] rem_q;
  logic [DATA_W-1:0] quo_q;
  logic [DATA_W-1:0] dvs_q;
  logic              neg_q;
  logic              neg_r;
  logic              dz_q;

  logic              a_neg;
  logic              b_neg;
  logic [DATA_W-1:0] a_mag;
  logic [DATA_W-1:0] b_mag;
  logic [DATA_W:0]   shifted;
  logic              fits;
  logic [DATA_W-1:0] diff;

  always_comb begin
    a_neg   = signed_mode & dividend[DATA_W-1];
    b_neg   = signed_mode & divisor[DATA_W-1];
    a_mag   = a_neg ? -dividend : dividend;
    b_mag   = b_neg ? -divisor : divisor;
    shifted = {rem_q, quo_q[DATA_W-1]};
    fits    = shifted >= {1'b0, dvs_q};
    // When the trial subtraction fits, the true difference is below
    // 2^DATA_W, so the low DATA_W bits of the wrapped result are exact.
    diff    = shifted[DATA_W-1:0] - dvs_q;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      active <= 1'b0;
      count  <= '0;
      rem_q  <= '0;
      quo_q  <= '0;
      dvs_q  <= '0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      dz_q   <= 1'b0;
    end else if (kill) begin
      active <= 1'b0;
      count  <= '0;
    end else if (start) begin
      active <= 1'b1;
      count  <= ITER_LOAD;
      rem_q  <= '0;
      quo_q  <= a_mag;
      dvs_q  <= b_mag;
      neg_q  <= a_neg ^ b_neg;
      neg_r  <= a_neg;
      dz_q   <= (divisor == '0);
    end else if (active) begin
      if (count != '0) begin
        count <= count - ITER_W'(1);
        rem_q <= fits ? diff : shifted[DATA_W-1:0];
        quo_q <= {quo_q[DATA_W-2:0], fits};
      end else begin
        active <= 1'b0;
      end
    end
  end

  // Sign fix happens combinationally in the terminal-count cycle.
  // A zero divisor forces an all-ones quotient; the remainder already
  // reconstructs the original dividend, including the most-negative case.
  always_comb begin
    done      = active && (count == '0);
    quotient  = dz_q ? '1 : (neg_q ? -quo_q : quo_q);
    remainder = neg_r ? -rem_q : rem_q;
  end

endmodule

// File: rtl/mul_div_ctrl.sv
// mul_div_ctrl
//   HI/LO multiply/divide unit controller. Accepts one request at a time
//   while idle; MULT/MULTU complete after MUL_LAT cycles through a
//   valid/data shift pipeline, DIV/DIVU through the iterative divider.
//   MTHI/MTLO write HI/LO directly, MFHI/MFLO return HI/LO one cycle later.
//
//   Build option
//     MUL_DIV_CTRL_DIV_EN  defined: divider present. Undefined: no divider,
//                          DIV/DIVU pulse op_err and leave HI/LO unchanged.
//
//   Ports
//     clk, resetn          clock, asynchronous active-low reset
//     in_valid, in_ready   request handshake
//     op                   operation (mul_div_pkg::op_t)
//     src_a, src_b         rs / rt operands
//     flush                kill in-flight operation, block acceptance
//     out_valid, out_data  MFHI/MFLO result pulse
//     busy                 multiply or divide in progress
//     op_err               unsupported operation accepted (pulse)
//
//   state   | meaning
//   IDLE    | ready for a request
//   MUL     | multiply pipeline in flight
//   DIV     | iterative divide in flight
module mul_div_ctrl
  import mul_div_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int MUL_LAT = 2
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        op,
  input  logic [DATA_W-1:0] src_a,
  input  logic [DATA_W-1:0] src_b,
  input  logic              flush,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic              busy,
  output logic              op_err
);

  state_t state;
  state_t state_nx;
  op_t    op_sel;

  logic accept;
  logic is_mul;
  logic is_div;
  logic is_mf;

  logic [2*DATA_W-1:0] ext_a;
  logic [2*DATA_W-1:0] ext_b;
  logic [2*DATA_W-1:0] product;
  logic [MUL_LAT-1:0]  pipe_v;
  logic [2*DATA_W-1:0] pipe_d [MUL_LAT];
  logic                mul_done;

  logic [DATA_W-1:0] hi;
  logic [DATA_W-1:0] lo;

  always_comb begin
    op_sel = op_t'(op);
    accept = in_valid && in_ready;
    is_mul = (op_sel == OP_MULT) || (op_sel == OP_MULTU);
    is_div = (op_sel == OP_DIV) || (op_sel == OP_DIVU);
    is_mf  = (op_sel == OP_MFHI) || (op_sel == OP_MFLO);
  end

`ifdef MUL_DIV_CTRL_DIV_EN
  logic              div_done;
  logic [DATA_W-1:0] div_q;
  logic [DATA_W-1:0] div_r;

  div_iter #(
    .DATA_W(DATA_W)
  ) u_div_iter (
    .clk        (clk),
    .resetn     (resetn),
    .start      (accept && is_div),
    .signed_mode(op_sel == OP_DIV),
    .kill       (flush),
    .dividend   (src_a),
    .divisor    (src_b),
    .done       (div_done),
    .quotient   (div_q),
    .remainder  (div_r)
  );
`endif

  // Truncated 2*DATA_W product of extended operands equals the signed
  // product when sign-extended and the unsigned one when zero-extended.
  always_comb begin
    ext_a   = (op_sel == OP_MULT) ? {{DATA_W{src_a[DATA_W-1]}}, src_a}
                                  : {{DATA_W{1'b0}}, src_a};
    ext_b   = (op_sel == OP_MULT) ? {{DATA_W{src_b[DATA_W-1]}}, src_b}
                                  : {{DATA_W{1'b0}}, src_b};
    product = ext_a * ext_b;
  end

  assign mul_done = pipe_v[MUL_LAT-1];

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      pipe_v <= '0;
      for (int i = 0; i < MUL_LAT; i++) pipe_d[i] <= '0;
    end else begin
      pipe_v[0] <= accept && is_mul && !flush;
      pipe_d[0] <= product;
      for (int i = 1; i < MUL_LAT; i++) begin
        pipe_v[i] <= pipe_v[i-1] && !flush;
        pipe_d[i] <= pipe_d[i-1];
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= ST_IDLE;
    else         state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE: begin
        if (accept && is_mul) state_nx = ST_MUL;
`ifdef MUL_DIV_CTRL_DIV_EN
        else if (accept && is_div) state_nx = ST_DIV;
`endif
      end
      ST_MUL: if (flush || mul_done) state_nx = ST_IDLE;
`ifdef MUL_DIV_CTRL_DIV_EN
      ST_DIV: if (flush || div_done) state_nx = ST_IDLE;
`endif
      default: state_nx = ST_IDLE;
    endcase
  end

  always_comb begin
    in_ready = (state == ST_IDLE) && !flush;
    busy     = (state != ST_IDLE);
  end

  // A flush on the completing edge discards the result.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      hi <= '0;
      lo <= '0;
    end else if (mul_done && !flush) begin
      {hi, lo} <= pipe_d[MUL_LAT-1];
`ifdef MUL_DIV_CTRL_DIV_EN
    end else if (div_done && !flush) begin
      lo <= div_q;
      hi <= div_r;
`endif
    end else if (accept && op_sel == OP_MTHI) begin
      hi <= src_a;
    end else if (accept && op_sel == OP_MTLO) begin
      lo <= src_a;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      op_err    <= 1'b0;
    end else begin
      out_valid <= accept && is_mf;
      if (accept && is_mf) out_data <= (op_sel == OP_MFHI) ? hi : lo;
`ifdef MUL_DIV_CTRL_DIV_EN
      op_err <= 1'b0;
`else
      op_err <= accept && is_div;
`endif
    end
  end

endmodule

// File: tb/tb_mul_div_ctrl.sv
module tb_mul_div_ctrl;
  import mul_div_pkg::*;

  localparam int W       = 32;
  localparam int MUL_LAT = 2;

  logic         clk = 1'b0;
  logic         resetn = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [2:0]   op = 3'd0;
  logic [W-1:0] src_a = '0;
  logic [W-1:0] src_b = '0;
  logic         flush = 1'b0;
  logic         out_valid;
  logic [W-1:0] out_data;
  logic         busy;
  logic         op_err;

  int n_chk  = 0;
  int n_fail = 0;

  mul_div_ctrl #(
    .DATA_W (W),
    .MUL_LAT(MUL_LAT)
  ) dut (
    .clk      (clk),
    .resetn   (resetn),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .op       (op),
    .src_a    (src_a),
    .src_b    (src_b),
    .flush    (flush),
    .out_valid(out_valid),
    .out_data (out_data),
    .busy     (busy),
    .op_err   (op_err)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic send(input op_t o, input logic [W-1:0] a, input logic [W-1:0] b);
    in_valid = 1'b1;
    op       = o;
    src_a    = a;
    src_b    = b;
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic read_reg(input string tag, input op_t o, output logic [W-1:0] d);
    send(o, '0, '0);
    @(negedge clk);
    check({tag, "_out_valid"}, 64'(out_valid), 64'd1);
    d = out_data;
  endtask

  task automatic expect_hilo(input string tag, input logic [W-1:0] e_hi, input logic [W-1:0] e_lo);
    logic [W-1:0] d;
    read_reg({tag, "_hi"}, OP_MFHI, d);
    check({tag, "_hi"}, 64'(d), 64'(e_hi));
    read_reg({tag, "_lo"}, OP_MFLO, d);
    check({tag, "_lo"}, 64'(d), 64'(e_lo));
  endtask

  task automatic wait_idle(input string tag, output int n);
    bit idle_f;
    idle_f = 1'b0;
    n = 0;
    for (int k = 0; k < 100 && !idle_f; k++) begin
      @(negedge clk);
      if (busy) n++;
      else idle_f = 1'b1;
    end
    if (!idle_f) check({tag, "_busy_timeout"}, 64'(busy), 64'd0);
  endtask

  typedef struct {
    op_t          o;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] hi;
    logic [W-1:0] lo;
  } vec_t;

  vec_t mv[5];
`ifdef MUL_DIV_CTRL_DIV_EN
  vec_t dv[6];
`endif

  initial begin
    logic [W-1:0] d;
    int           n;
    int           waits;
    bit           got_f;

    mv[0] = '{OP_MULT,  32'hFFFFFFFE, 32'd3,        32'hFFFFFFFF, 32'hFFFFFFFA};
    mv[1] = '{OP_MULTU, 32'hFFFFFFFE, 32'd3,        32'h00000002, 32'hFFFFFFFA};
    mv[2] = '{OP_MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000};
    mv[3] = '{OP_MULT,  32'h7FFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h80000001};
    mv[4] = '{OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001};
`ifdef MUL_DIV_CTRL_DIV_EN
    dv[0] = '{OP_DIV,  32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD};
    dv[1] = '{OP_DIVU, 32'd7,        32'd0,        32'h00000007, 32'hFFFFFFFF};
    dv[2] = '{OP_DIV,  32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000};
    dv[3] = '{OP_DIV,  32'd7,        32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD};
    dv[4] = '{OP_DIVU, 32'd100,      32'd7,        32'h00000002, 32'h0000000E};
    dv[5] = '{OP_DIV,  32'hFFFFFFF9, 32'd0,        32'hFFFFFFF9, 32'hFFFFFFFF};
`endif

    // reset state
    repeat (3) @(negedge clk);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_data", 64'(out_data), 64'd0);
    check("rst_op_err", 64'(op_err), 64'd0);

    // first request on the first edge after release
    resetn = 1'b1;
    check("post_rst_in_ready", 64'(in_ready), 64'd1);
    read_reg("post_rst_mflo", OP_MFLO, d);
    check("post_rst_mflo", 64'(d), 64'd0);
    @(negedge clk);
    check("out_valid_pulse", 64'(out_valid), 64'd0);

    // MTHI/MTLO back to back, read back
    send(OP_MTHI, 32'hDEADBEEF, '0);
    send(OP_MTLO, 32'h01234567, '0);
    expect_hilo("mt", 32'hDEADBEEF, 32'h01234567);

    // multiply vectors
    foreach (mv[i]) begin
      send(mv[i].o, mv[i].a, mv[i].b);
      wait_idle($sformatf("mul%0d", i), n);
      check($sformatf("mul%0d_busy_cycles", i), 64'(n), 64'(MUL_LAT));
      expect_hilo($sformatf("mul%0d", i), mv[i].hi, mv[i].lo);
    end

    // MFHI presented right behind a MULTU waits for the result
    send(OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF);
    in_valid = 1'b1;
    op       = OP_MFHI;
    waits    = 0;
    got_f    = 1'b0;
    for (int k = 0; k < 20 && !got_f; k++) begin
      @(negedge clk);
      if (in_ready) got_f = 1'b1;
      else waits++;
    end
    check("interlock_waits", 64'(waits), 64'(MUL_LAT));
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(negedge clk);
    check("interlock_out_valid", 64'(out_valid), 64'd1);
    check("interlock_mfhi", 64'(out_data), 64'hFFFFFFFE);

    // flush mid-multiply
    send(OP_MTHI, 32'h1234, '0);
    send(OP_MTLO, 32'h5678, '0);
    send(OP_MULT, 32'd5, 32'd5);
    flush = 1'b1;
    @(posedge clk);
    #1 flush = 1'b0;
    @(negedge clk);
    check("mul_flush_busy", 64'(busy), 64'd0);
    repeat (4) @(negedge clk);
    expect_hilo("mul_flush", 32'h1234, 32'h5678);

    // flush on the completing multiply edge
    send(OP_MULT, 32'd5, 32'd5);
    @(posedge clk);
    #1;
    check("mul_final_busy_pre", 64'(busy), 64'd1);
    flush = 1'b1;
    @(posedge clk);
    #1 flush = 1'b0;
    @(negedge clk);
    check("mul_final_flush_busy", 64'(busy), 64'd0);
    expect_hilo("mul_final_flush", 32'h1234, 32'h5678);

    // flush beats in_valid
    @(negedge clk);
    in_valid = 1'b1;
    op       = OP_MTHI;
    src_a    = 32'h9999;
    flush    = 1'b1;
    #1 check("flush_in_ready", 64'(in_ready), 64'd0);
    @(posedge clk);
    #1 begin
      in_valid = 1'b0;
      flush    = 1'b0;
    end
    expect_hilo("flush_vs_valid", 32'h1234, 32'h5678);

`ifdef MUL_DIV_CTRL_DIV_EN
    foreach (dv[i]) begin
      send(dv[i].o, dv[i].a, dv[i].b);
      wait_idle($sformatf("div%0d", i), n);
      check($sformatf("div%0d_busy_cycles", i), 64'(n), 64'(W + 1));
      expect_hilo($sformatf("div%0d", i), dv[i].hi, dv[i].lo);
    end

    // flush at cycle 10 of a divide
    send(OP_MTHI, 32'h1234, '0);
    send(OP_MTLO, 32'h5678, '0);
    send(OP_DIV, 32'd100, 32'd7);
    repeat (9) @(negedge clk);
    check("div_flush_busy_pre", 64'(busy), 64'd1);
    flush = 1'b1;
    @(posedge clk);
    #1 flush = 1'b0;
    @(negedge clk);
    check("div_flush_busy", 64'(busy), 64'd0);
    repeat (40) @(negedge clk);
    expect_hilo("div_flush", 32'h1234, 32'h5678);
`else
    send(OP_MTHI, 32'hAAAA, '0);
    send(OP_MTLO, 32'hBBBB, '0);
    send(OP_DIV, 32'd7, 32'd2);
    @(negedge clk);
    check("nodiv_op_err", 64'(op_err), 64'd1);
    check("nodiv_busy", 64'(busy), 64'd0);
    @(negedge clk);
    check("nodiv_op_err_pulse", 64'(op_err), 64'd0);
    send(OP_DIVU, 32'd7, 32'd0);
    @(negedge clk);
    check("nodiv_divu_op_err", 64'(op_err), 64'd1);
    expect_hilo("nodiv", 32'hAAAA, 32'hBBBB);
`endif

    // reset mid-operation
    send(OP_MTLO, 32'h77, '0);
`ifdef MUL_DIV_CTRL_DIV_EN
    send(OP_DIV, 32'd100, 32'd7);
`else
    send(OP_MULT, 32'd100, 32'd7);
`endif
    @(negedge clk);
    check("rst_mid_busy_pre", 64'(busy), 64'd1);
    resetn = 1'b0;
    #1;
    check("rst_mid_busy", 64'(busy), 64'd0);
    check("rst_mid_out_valid", 64'(out_valid), 64'd0);
    check("rst_mid_out_data", 64'(out_data), 64'd0);
    check("rst_mid_op_err", 64'(op_err), 64'd0);
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    repeat (40) @(negedge clk);
    check("rst_mid_busy_after", 64'(busy), 64'd0);
    expect_hilo("rst_mid", 32'h0, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
